// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game controller: button edge detection, play/pause/over FSM,
// flap and gravity command pulses, BCD score and best-score tracking.
module flappy_game_ctrl #(
   parameter int GRAV_PERIOD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       flap_btn,
   input  logic       collision,
   input  logic       pipe_pass,
   output logic       pause,
   output logic       key,
   output logic       gravity,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic [3:0] best_tens,
   output logic [3:0] best_ones,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, PLAY, PAUSED, OVER} state_t;

   state_t      state, state_nxt;
   logic [2:0]  btn_now, btn_prev, btn_armed, btn_edge;
   logic        start_e, pause_e, flap_e;
   logic        flap_lat;
   logic [3:0]  grav_cnt;
   logic        grav_hit;
   logic [7:0]  score, best, score_nxt;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99)
         r = v;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // A button only produces an edge after it has been seen low at least once
   // since reset, so a key held through reset stays silent.
   assign btn_now  = {flap_btn, pause_btn, start_btn};
   assign btn_edge = btn_now & ~btn_prev & btn_armed;
   assign start_e  = btn_edge[0];
   assign pause_e  = btn_edge[1];
   assign flap_e   = btn_edge[2];

   assign grav_hit  = tick && (grav_cnt == 4'(GRAV_PERIOD - 1));
   assign score_nxt = pipe_pass ? bcd_inc_sat(score) : score;

   assign score_tens = score[7:4];
   assign score_ones = score[3:0];
   assign best_tens  = best[7:4];
   assign best_ones  = best[3:0];

   // Edge-detect history and arming flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_prev  <= 3'b000;
         btn_armed <= 3'b000;
      end else begin
         btn_prev  <= btn_now;
         btn_armed <= btn_armed | ~btn_now;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and command outputs; collision outranks pause in PLAY.
   always_comb begin
      state_nxt = state;
      pause     = 1'b1;
      key       = 1'b0;
      gravity   = 1'b0;
      game_over = 1'b0;
      case (state)
         IDLE: begin
            if (start_e) state_nxt = PLAY;
         end
         PLAY: begin
            pause   = 1'b0;
            key     = tick && (flap_lat || flap_e);
            gravity = grav_hit;
            if (collision)    state_nxt = OVER;
            else if (pause_e) state_nxt = PAUSED;
         end
         PAUSED: begin
            if (pause_e) state_nxt = PLAY;
         end
         OVER: begin
            game_over = 1'b1;
            if (start_e) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gravity counter, flap latch, score and best score.
   always_ff @(posedge clk) begin
      if (reset) begin
         grav_cnt <= 4'd0;
         flap_lat <= 1'b0;
         score    <= 8'h00;
         best     <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start_e) begin
                  grav_cnt <= 4'd0;
                  flap_lat <= 1'b0;
                  score    <= 8'h00;
               end
            end
            PLAY: begin
               if (tick)
                  grav_cnt <= grav_hit ? 4'd0 : grav_cnt + 4'd1;
               if (tick)
                  flap_lat <= 1'b0;
               else if (flap_e)
                  flap_lat <= 1'b1;
               score <= score_nxt;
               // BCD digits order the same way as the binary value.
               if (collision && (score_nxt > best))
                  best <= score_nxt;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
